// File: rtl/csr_arb_pkg.sv
// Shared state encoding and constants for the two-master CSR arbiter.
package csr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } arb_state_t;

    localparam logic [31:0] ABORT_READDATA = 32'hDEADBEEF;
    localparam int          CNT_W          = 10;

endpackage

// File: rtl/csr_arb_rr2.sv
// Two-way round-robin pick: returns the index of the master to grant.
module csr_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    // On a tie the master not served last wins; otherwise the lone requester.
    assign grant = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/csr_master_arbiter.sv
// Arbitrates two CSR masters onto one decoder slave port.
// Define CSR_ARB_TIMEOUT_EN to abort transfers stalled for TIMEOUT_CYCLES.
module csr_master_arbiter
    import csr_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        csr_clk_clk,
    input  logic        csr_clk_reset_reset,
    input  logic [15:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    output logic [31:0] m0_readdata,
    output logic        m0_waitrequest,
    input  logic [15:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    output logic [31:0] m1_readdata,
    output logic        m1_waitrequest,
    output logic [15:0] dec_address,
    output logic        dec_read,
    output logic        dec_write,
    output logic [31:0] dec_writedata,
    input  logic [31:0] dec_readdata,
    input  logic        dec_waitrequest,
    output logic        timeout_flag,
    input  logic        timeout_clr
);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic       r_last;
    logic       r_gnt;
    logic       w_req0;
    logic       w_req1;
    logic       w_rr_grant;
    logic       w_sel_req;
    logic       w_sel_write;
    logic       w_done;
    logic       w_timeout_hit;

    assign w_req0      = m0_read | m0_write;
    assign w_req1      = m1_read | m1_write;
    assign w_sel_req   = r_gnt ? w_req1 : w_req0;
    assign w_sel_write = r_gnt ? m1_write : m0_write;

    csr_arb_rr2 u_rr2 (
        .req   ({w_req1, w_req0}),
        .last  (r_last),
        .grant (w_rr_grant)
    );

`ifdef CSR_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_timeout_flag;

    assign w_cnt_inc     = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_timeout_hit = dec_waitrequest && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    assign timeout_flag  = r_timeout_flag;

    always_ff @(posedge csr_clk_clk) begin
        if (csr_clk_reset_reset) begin
            r_cnt          <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            if (r_state == IDLE)
                r_cnt <= '0;
            else if ((r_state == GRANT0 || r_state == GRANT1) && dec_waitrequest)
                r_cnt <= w_cnt_inc;

            // Setting on abort entry takes priority over a same-cycle clear.
            if (r_state != ABORT && w_state_next == ABORT)
                r_timeout_flag <= 1'b1;
            else if (timeout_clr)
                r_timeout_flag <= 1'b0;
        end
    end
`else
    logic w_unused;

    assign w_timeout_hit = 1'b0;
    assign timeout_flag  = 1'b0;
    assign w_unused      = timeout_clr | (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge csr_clk_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (csr_clk_reset_reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && (w_req0 || w_req1))
                r_gnt <= w_rr_grant;
            if (w_done)
                r_last <= r_gnt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        w_state_next   = r_state;
        w_done         = 1'b0;
        dec_address    = '0;
        dec_read       = 1'b0;
        dec_write      = 1'b0;
        dec_writedata  = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;

        case (r_state)
            IDLE: begin
                if (w_req0 || w_req1)
                    w_state_next = w_rr_grant ? GRANT1 : GRANT0;
            end
            GRANT0, GRANT1: begin
                dec_address   = r_gnt ? m1_address : m0_address;
                dec_writedata = r_gnt ? m1_writedata : m0_writedata;
                dec_write     = w_sel_write;
                dec_read      = (r_gnt ? m1_read : m0_read) & ~w_sel_write;
                if (r_gnt) begin
                    m1_waitrequest = dec_waitrequest;
                    m1_readdata    = dec_readdata;
                end else begin
                    m0_waitrequest = dec_waitrequest;
                    m0_readdata    = dec_readdata;
                end

                if (!w_sel_req) begin
                    w_state_next = IDLE;
                end else if (!dec_waitrequest) begin
                    w_state_next = IDLE;
                    w_done       = 1'b1;
                end else if (w_timeout_hit) begin
                    w_state_next = ABORT;
                end
            end
            ABORT: begin
                if (r_gnt) begin
                    m1_waitrequest = 1'b0;
                    m1_readdata    = ABORT_READDATA;
                end else begin
                    m0_waitrequest = 1'b0;
                    m0_readdata    = ABORT_READDATA;
                end
                w_state_next = IDLE;
                w_done       = 1'b1;
            end
            default: w_state_next = IDLE;
        endcase
    end

endmodule

// File: doc/csr_master_arbiter.md
CSR_MASTER_ARBITER -- requirements
Module: csr_master_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023: downstream waitrequest cycles tolerated before abort (1..1023).
REQ-002 SHALL have port csr_clk_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port csr_clk_reset_reset, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have ports m0_address/m1_address, input, 16: master word address.
REQ-005 SHALL have ports m0_read/m1_read and m0_write/m1_write, input, 1 each: command strobes.
REQ-006 SHALL have ports m0_writedata/m1_writedata, input, 32, and m0_readdata/m1_readdata, output, 32.
REQ-007 SHALL have ports m0_waitrequest/m1_waitrequest, output, 1: master stall.
REQ-008 SHALL have ports dec_address (output, 16), dec_read (output, 1), dec_write (output, 1), dec_writedata (output, 32): the shared channel decoder slave port.
REQ-009 SHALL have ports dec_readdata (input, 32) and dec_waitrequest (input, 1): decoder responses.
REQ-010 SHALL have port timeout_flag, output, 1: sticky abort indicator.
REQ-011 SHALL have port timeout_clr, input, 1: clears timeout_flag.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT0, GRANT1, ABORT.
REQ-013 SHALL treat a master as requesting when read|write is high; read+write together SHALL be treated as write, with dec_read held 0.
REQ-014 In IDLE with one requester, SHALL enter that master's GRANT state at the next edge.
REQ-015 In IDLE with both requesting, SHALL grant the master not granted last (round-robin); after reset, m0 wins.
REQ-016 dec_* command outputs SHALL be combinational muxes of the granted master's signals; in IDLE/ABORT they SHALL be 0.
REQ-017 The granted master SHALL see waitrequest = dec_waitrequest and readdata = dec_readdata; the non-granted master SHALL see waitrequest=1 and readdata=0.
REQ-018 In IDLE, both waitrequests SHALL be 1 (minimum latency: request at cycle N, command on dec_* at cycle N+1).
REQ-019 On dec_waitrequest=0 while granted and requesting, transfer completes; SHALL return to IDLE at the next edge and record the grantee as last-granted.
REQ-020 If the granted master drops read and write while granted, SHALL return to IDLE without recording completion.
REQ-021 A wait counter SHALL clear on grant and increment each cycle dec_waitrequest=1 in GRANT; it SHALL saturate, never wrap.

Reset
REQ-022 On reset, SHALL enter IDLE, set last-granted=m1 (so m0 wins first), clear the wait counter and timeout_flag; all dec_* outputs 0, both waitrequests 1, both readdata 0.
REQ-023 Reset during GRANT SHALL drop dec_read/dec_write at that edge; the aborted transfer is not retried.

Configuration
REQ-024 With CSR_ARB_TIMEOUT_EN defined: when the wait counter reaches TIMEOUT_CYCLES in GRANT, SHALL enter ABORT; ABORT lasts one cycle with granted master waitrequest=0, readdata=32'hDEADBEEF, dec_* commands 0; then IDLE, with the grantee recorded as last-granted.
REQ-025 With CSR_ARB_TIMEOUT_EN defined: timeout_flag SHALL set on ABORT entry and clear on timeout_clr; if both occur in the same cycle, set wins.
REQ-026 Without CSR_ARB_TIMEOUT_EN: ABORT is unreachable, the counter is removed, timeout_flag is tied 0, and timeout_clr is ignored.

Structure
REQ-027 SHALL place the FSM state enum, the DEADBEEF abort constant and the counter width (10) in package csr_arb_pkg.
REQ-028 SHALL implement round-robin selection in sub-module csr_arb_rr2 (inputs req[1:0], last; output grant index).

Verification
REQ-029 SHALL cover: m0 write 0x0123 data 0xA5A5A5A5, dec_waitrequest low after 2 cycles -> dec_write high 3 cycles with matching address/data, then m0_waitrequest=0 for one cycle and IDLE.
REQ-030 SHALL cover: both masters read in the same cycle after reset -> m0 served first, then m1; next tie -> m0 first again.
REQ-031 SHALL cover: m1 read, dec_readdata 0x12345678 with waitrequest=0 -> m1_readdata=0x12345678 the same cycle; m0_readdata=0.
REQ-032 SHALL cover: read+write asserted together -> dec_write=1, dec_read=0.
REQ-033 SHALL cover (macro on, TIMEOUT_CYCLES=8): dec_waitrequest stuck high -> abort after 8 stall cycles, readdata 0xDEADBEEF, timeout_flag=1 until timeout_clr.
REQ-034 SHALL cover: reset asserted mid-GRANT -> dec_write=0 and both waitrequests=1 the following cycle.
